// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer control for an async FIFO: binary/Gray write pointer,
// full / almost-full / level from the synchronized read pointer, sticky overflow.
module fifo_wr_ptr_ctrl #(
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic              a_clk,
  input  logic              a_rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W:0]   rd_gptr_sync,
  input  logic              clr_ovf,
  output logic              wr_en_mem,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_gptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wr_bin_q,  wr_bin_d;
  logic [PW-1:0] wr_gptr_q, wr_gptr_d;
  logic [PW-1:0] level_q,   level_d;
  logic          full_q,    full_d;
  logic          afull_q,   afull_d;
  logic          ovf_q,     ovf_d;
  logic [PW-1:0] rd_bin;
  logic          accept;

  // Reset gates the strobe so no write escapes while flops are held clear.
  assign accept    = wr_req & ~full_q & a_rst_n;
  assign wr_en_mem = accept;

  always_comb begin
    wr_bin_d  = wr_bin_q;
    wr_gptr_d = wr_gptr_q;
    rd_bin    = gray2bin(rd_gptr_sync);
    if (accept) begin
      wr_bin_d = wr_bin_q + PW'(1);
    end
    wr_gptr_d = wr_bin_d ^ (wr_bin_d >> 1);
    level_d   = wr_bin_d - rd_bin;
    // Full when the next write pointer is one lap ahead of the read pointer.
    full_d    = (wr_gptr_d == {~rd_gptr_sync[PW-1:PW-2], rd_gptr_sync[PW-3:0]});
    afull_d   = (level_d >= AFULL_LVL);
    ovf_d     = (wr_req & full_q) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_bin_q  <= '0;
      wr_gptr_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gptr_q <= wr_gptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_addr     = wr_bin_q[ADDR_W-1:0];
  assign wr_gptr     = wr_gptr_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Scoreboard bench for fifo_wr_ptr_ctrl: stimulus pushes expected outputs,
// a monitor pops and compares each cycle.
module tb_fifo_wr_ptr_ctrl;

  logic       a_clk = 1'b0;
  logic       a_rst_n = 1'b0;
  logic       wr_req = 1'b0;
  logic [3:0] rd_gptr_sync = 4'd0;
  logic       clr_ovf = 1'b0;
  logic       wr_en_mem;
  logic [2:0] wr_addr;
  logic [3:0] wr_gptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  fifo_wr_ptr_ctrl #(.ADDR_W(3), .AFULL_THRESH(6)) dut (
    .a_clk(a_clk), .a_rst_n(a_rst_n), .wr_req(wr_req), .rd_gptr_sync(rd_gptr_sync),
    .clr_ovf(clr_ovf), .wr_en_mem(wr_en_mem), .wr_addr(wr_addr), .wr_gptr(wr_gptr),
    .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 a_clk = ~a_clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] addr;
    logic [3:0] gptr;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Hand-written 4-bit Gray table.
  function automatic logic [3:0] gray_of(input logic [3:0] b);
    case (b)
      4'd0: return 4'b0000;  4'd1: return 4'b0001;  4'd2: return 4'b0011;  4'd3: return 4'b0010;
      4'd4: return 4'b0110;  4'd5: return 4'b0111;  4'd6: return 4'b0101;  4'd7: return 4'b0100;
      4'd8: return 4'b1100;  4'd9: return 4'b1101;  4'd10: return 4'b1111; 4'd11: return 4'b1110;
      4'd12: return 4'b1010; 4'd13: return 4'b1011; 4'd14: return 4'b1001; default: return 4'b1000;
    endcase
  endfunction

  function automatic void chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, want, $time);
    end
  endfunction

  // Bench model state
  logic [3:0] m_wbin = 4'd0;
  logic [3:0] m_rdb = 4'd0;
  logic [3:0] m_lvl = 4'd0;
  logic       m_full = 1'b0;
  logic       m_af = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic step(input logic rst, input logic wr, input logic clr, input logic [3:0] rdb);
    exp_t e;
    logic acc;
    logic ovf_n;
    @(negedge a_clk);
    #1;
    a_rst_n = rst;
    wr_req = wr;
    clr_ovf = clr;
    rd_gptr_sync = gray_of(rdb);
    m_rdb = rdb;
    e.rst = rst;
    if (!rst) begin
      m_wbin = 4'd0; m_lvl = 4'd0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
      e.en = 1'b0; e.addr = 3'd0; e.gptr = 4'd0; e.full = 1'b0; e.af = 1'b0;
      e.lvl = 4'd0; e.ovf = 1'b0;
      q.push_back(e);
    end else begin
      acc = wr & ~m_full;
      e.en = acc; e.addr = m_wbin[2:0]; e.gptr = gray_of(m_wbin); e.full = m_full;
      e.af = m_af; e.lvl = m_lvl; e.ovf = m_ovf;
      q.push_back(e);
      ovf_n = (wr & m_full) | (m_ovf & ~clr);
      m_wbin = m_wbin + {3'd0, acc};
      m_lvl = m_wbin - rdb;
      m_full = (m_lvl == 4'd8);
      m_af = (m_lvl >= 4'd6);
      m_ovf = ovf_n;
    end
  endtask

  // Monitor: compares the outputs presented in each stimulated cycle.
  initial begin : monitor
    exp_t e;
    logic [3:0] prev_g = 4'd0;
    logic prev_ok = 1'b0;
    forever begin
      @(negedge a_clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_en_mem", int'(wr_en_mem), int'(e.en));
        chk("wr_addr", int'(wr_addr), int'(e.addr));
        chk("wr_gptr", int'(wr_gptr), int'(e.gptr));
        chk("full", int'(full), int'(e.full));
        chk("almost_full", int'(almost_full), int'(e.af));
        chk("wr_level", int'(wr_level), int'(e.lvl));
        chk("overflow", int'(overflow), int'(e.ovf));
        if (prev_ok && e.rst) begin
          chk("gray_step_le1", int'($countones(wr_gptr ^ prev_g) <= 1), 1);
        end
        prev_g = wr_gptr;
        prev_ok = e.rst;
      end
    end
  end

  initial begin : stim
    logic [3:0] lvl;
    logic [3:0] rdb;
    // Reset held with a write request pending
    repeat (3) step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    // Fill 8 entries
    repeat (8) step(1'b1, 1'b1, 1'b0, 4'd0);
    // Overflow: two rejected writes, then clear, then clear racing a set
    repeat (2) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    // Drain in one jump then refill across the pointer wrap
    step(1'b1, 1'b0, 1'b0, 4'd8);
    step(1'b1, 1'b0, 1'b0, 4'd8);
    repeat (8) step(1'b1, 1'b1, 1'b0, 4'd8);
    step(1'b1, 1'b0, 1'b0, 4'd8);
    step(1'b1, 1'b1, 1'b0, 4'd8);
    // Mid-operation reset after 5 writes
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    // Random traffic with a legal, monotonic read pointer
    for (int i = 0; i < 10000; i++) begin
      lvl = m_wbin - m_rdb;
      rdb = m_rdb;
      if (lvl != 4'd0 && $urandom_range(0, 1) == 1) rdb = m_rdb + 4'd1;
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), rdb);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge a_clk);
    #5;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
FIFO_WR_PTR_CTRL -- requirements
Module: fifo_wr_ptr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 3, memory address width; FIFO depth = 2**ADDR_W; pointer width PW = ADDR_W+1 (4 at default, matching the 4-bit pointer synchronizer).
REQ-002 Parameter AFULL_THRESH, default 6, occupancy at or above which almost_full asserts; legal range 1..2**ADDR_W.
REQ-003 a_clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 a_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_req  input  1  producer write request, one word per cycle.
REQ-006 rd_gptr_sync  input  PW  Gray-coded read pointer, already synchronized into the a_clk domain.
REQ-007 clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 wr_en_mem  output  1  memory write strobe (combinational).
REQ-009 wr_addr  output  ADDR_W  memory write address (registered).
REQ-010 wr_gptr  output  PW  Gray-coded write pointer to the write-to-read synchronizer (registered).
REQ-011 full  output  1  FIFO full (registered).
REQ-012 almost_full  output  1  occupancy >= AFULL_THRESH (registered).
REQ-013 wr_level  output  PW  write-side occupancy estimate, 0..2**ADDR_W (registered).
REQ-014 overflow  output  1  sticky flag: write attempted while full.

Function
REQ-015 Internal binary pointer wr_bin (PW bits) and Gray pointer wr_gptr = wr_bin ^ (wr_bin >> 1) shall be held in flops.
REQ-016 accept = wr_req & ~full; wr_en_mem shall equal accept in the same cycle; wr_addr shall equal wr_bin[ADDR_W-1:0].
REQ-017 On accept: wr_bin <= wr_bin+1 (mod 2**PW, wraps from all-ones to 0); wr_gptr <= gray(wr_bin+1). Otherwise both hold.
REQ-018 wr_gptr shall change in at most one bit per a_clk edge and shall be driven directly from a flop (no combinational logic into the synchronizer).
REQ-019 full shall be registered from next-state values: full_next = (gray(wr_bin_next) == {~rd_gptr_sync[PW-1:PW-2], rd_gptr_sync[PW-3:0]}); full shall assert on the edge that accepts the last free entry.
REQ-020 full shall deassert on the first edge after rd_gptr_sync advances; no write is accepted while full = 1.
REQ-021 rd_bin = Gray-to-binary of rd_gptr_sync; wr_level <= (wr_bin_next - rd_bin) mod 2**PW; value never exceeds 2**ADDR_W.
REQ-022 almost_full <= (level_next >= AFULL_THRESH); full = 1 implies almost_full = 1.
REQ-023 overflow shall set on any cycle with wr_req & full; clr_ovf clears it; set wins when both occur in the same cycle.
REQ-024 A rejected write shall not change wr_bin, wr_gptr, wr_addr or wr_level.
REQ-025 rd_gptr_sync changing in the same cycle as an accept: both take effect; flags computed from the new rd_gptr_sync and wr_bin_next.

Reset
REQ-026 While a_rst_n = 0: wr_bin, wr_gptr, wr_addr, wr_level = 0; full, almost_full, overflow = 0; wr_en_mem = 0.
REQ-027 Reset asserted mid-operation shall clear all state immediately, independent of a_clk; first accept after release writes address 0.
REQ-028 Reset release shall be synchronized to a_clk externally; this block adds no reset synchronizer.

Verification
REQ-029 Reset: assert a_rst_n = 0 with wr_req = 1 -> all outputs 0, no wr_en_mem pulse.
REQ-030 Fill: rd_gptr_sync = 0000, 8 back-to-back writes -> wr_gptr steps 0001,0011,0010,0110,0111,0101,0100,1100; wr_addr 0..7; almost_full = 1 after 6th edge; full = 1 and wr_level = 8 after 8th edge.
REQ-031 Overflow: while full, wr_req = 1 for 2 cycles -> wr_en_mem = 0, wr_gptr stays 1100, overflow = 1; clr_ovf alone -> 0; clr_ovf with wr_req & full -> stays 1.
REQ-032 Drain/wrap: from full, set rd_gptr_sync = 1100 -> full = 0, wr_level = 0 next edge; 8 more writes wrap wr_bin 15 -> 0, wr_gptr 1000 -> 0000, full = 1 again only when rd_gptr_sync = 1100 and wr_gptr = 0000.
REQ-033 Gray property: random wr_req and legal rd_gptr_sync sequences for 10k cycles -> wr_gptr Hamming distance between consecutive cycles <= 1; wr_level always equals writes minus synced reads.
REQ-034 Mid-operation reset: after 5 writes, pulse a_rst_n low between edges -> outputs 0 immediately; next write uses wr_addr = 0, wr_gptr -> 0001.
